// File: rtl/unidade_entrada_saida.sv
// rtl/unidade_entrada_saida.sv - WAIT/INPUT/OUTPUT I/O stage with debounced confirm button (optional IO_TIMEOUT_EN)
module unidade_entrada_saida #(
  parameter int DATA_W          = 32,
  parameter int SW_W            = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ler_da_entrada,
  input  logic              confirma_entrada,
  input  logic              print,
  input  logic              botao_n,
  input  logic [SW_W-1:0]   chaves,
  input  logic [DATA_W-1:0] dado_saida,
  output logic              stall_pc,
  output logic [DATA_W-1:0] dado_entrada,
  output logic [DATA_W-1:0] display_valor,
  output logic              display_valido,
  output logic              aguardando,
  output logic              timeout_flag
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, DONE} state_t;

  state_t            state, state_next;
  logic              botao_s1, botao_s2;
  logic [SW_W-1:0]   chaves_s1, chaves_s2;
  logic              botao_estavel;
  logic [DB_W-1:0]   db_cnt;
  logic              db_flip, press_pulse, release_pulse;
  logic              wait_ativo, entra_wait, captura, to_hit;
  logic [SW_W-1:0]   entrada_reg;

  // The bus value is always presented; the control unit decides when to write it back.
  logic unused_confirma;
  assign unused_confirma = confirma_entrada;

  // Two-flop synchronizers; the button resets to its released (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      botao_s1  <= 1'b1;
      botao_s2  <= 1'b1;
      chaves_s1 <= '0;
      chaves_s2 <= '0;
    end else begin
      botao_s1  <= botao_n;
      botao_s2  <= botao_s1;
      chaves_s1 <= chaves;
      chaves_s2 <= chaves_s1;
    end
  end

  assign db_flip       = (botao_s2 != botao_estavel) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
  assign press_pulse   = db_flip & ~botao_s2;
  assign release_pulse = db_flip & botao_s2;

  // Debounce: accept a new level only after it has been seen for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      botao_estavel <= 1'b1;
      db_cnt        <= '0;
    end else if (botao_s2 == botao_estavel) begin
      db_cnt <= '0;
    end else if (db_flip) begin
      botao_estavel <= botao_s2;
      db_cnt        <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign wait_ativo = (state == WAIT_PRESS) || (state == WAIT_RELEASE);
  assign entra_wait = (state == IDLE) && ler_da_entrada;

`ifdef IO_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_flag;

  assign to_hit       = wait_ativo && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = to_flag;

  // Cycles spent inside WAIT; cleared whenever the FSM is outside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          to_cnt <= '0;
    else if (wait_ativo) to_cnt <= to_cnt + 1'b1;
    else                 to_cnt <= '0;
  end

  // Sticky abort indication, cleared when the next WAIT begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          to_flag <= 1'b0;
    else if (entra_wait) to_flag <= 1'b0;
    else if (to_hit)     to_flag <= 1'b1;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign to_hit       = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and switch-capture strobe.
  always_comb begin
    state_next = state;
    captura    = 1'b0;
    case (state)
      IDLE:         if (ler_da_entrada) state_next = WAIT_PRESS;
      WAIT_PRESS: begin
        if (press_pulse) begin
          captura    = 1'b1;
          state_next = WAIT_RELEASE;
        end
        if (to_hit) state_next = DONE;
      end
      WAIT_RELEASE: if (release_pulse || to_hit) state_next = DONE;
      DONE:         state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  assign stall_pc     = entra_wait | wait_ativo;
  assign aguardando   = (state == WAIT_PRESS);
  assign dado_entrada = DATA_W'(entrada_reg);

  // Switch value latched on the debounced press inside WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       entrada_reg <= '0;
    else if (captura) entrada_reg <= chaves_s2;
  end

  // Display register; prints issued while stalled are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_valor  <= '0;
      display_valido <= 1'b0;
    end else if (print && !stall_pc) begin
      display_valor  <= dado_saida;
      display_valido <= 1'b1;
    end
  end

endmodule

// File: tb/tb_unidade_entrada_saida.sv
// tb/tb_unidade_entrada_saida.sv - randomized self-checking bench for unidade_entrada_saida
module tb_unidade_entrada_saida;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ler_da_entrada, confirma_entrada, print, botao_n;
  logic [15:0] chaves;
  logic [31:0] dado_saida;
  logic        stall_pc, display_valido, aguardando, timeout_flag;
  logic [31:0] dado_entrada, display_valor;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_entrada = 32'h0;
  logic [31:0] exp_disp    = 32'h0;
  logic        exp_valid   = 1'b0;

  unidade_entrada_saida #(
    .DATA_W(32), .SW_W(16), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ler_da_entrada(ler_da_entrada),
    .confirma_entrada(confirma_entrada), .print(print), .botao_n(botao_n),
    .chaves(chaves), .dado_saida(dado_saida), .stall_pc(stall_pc),
    .dado_entrada(dado_entrada), .display_valor(display_valor),
    .display_valido(display_valido), .aguardando(aguardando),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_print(input logic [31:0] d);
    dado_saida = d;
    print      = 1'b1;
    tick();
    print      = 1'b0;
    exp_disp   = d;
    exp_valid  = 1'b1;
  endtask

  // One full WAIT instruction; the switch value at the accepted press must be captured.
  task automatic do_wait(input logic [15:0] val, input bit bounce, input bit pre_held);
    int n;
    chaves = ~val;
    if (pre_held) begin
      botao_n = 1'b0;
      repeat (10) tick();
      check("press_outside_wait", dado_entrada, exp_entrada);
    end
    ler_da_entrada = 1'b1;
    print          = 1'b1;
    dado_saida     = $urandom;
    #1;
    check("stall_at_decode", {31'b0, stall_pc}, 32'd1);
    tick();
    print = 1'b0;
    check("print_during_wait", display_valor, exp_disp);
    check("aguardando_on", {31'b0, aguardando}, 32'd1);
    check("timeout_flag_clear", {31'b0, timeout_flag}, 32'd0);
    if (pre_held) begin
      repeat (8) tick();
      check("held_no_capture", {31'b0, aguardando}, 32'd1);
      botao_n = 1'b1;
      repeat (8) tick();
      check("release_no_capture", {31'b0, aguardando}, 32'd1);
      check("held_stall", {31'b0, stall_pc}, 32'd1);
    end
    if (bounce) begin
      for (int i = 0; i < 10; i++) begin
        botao_n = ~botao_n;
        repeat (2) tick();
      end
      check("bounce_no_capture", {31'b0, aguardando}, 32'd1);
      check("bounce_value", dado_entrada, exp_entrada);
    end
    botao_n = 1'b0;
    chaves  = val;
    repeat (5) tick();
    check("debounce_early", {31'b0, aguardando}, 32'd1);
    tick();
    check("debounce_capture", {31'b0, aguardando}, 32'd0);
    exp_entrada = {16'h0, val};
    check("capture_value", dado_entrada, exp_entrada);
    repeat (4) tick();
    check("stall_while_held", {31'b0, stall_pc}, 32'd1);
    botao_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (stall_pc && n < 40);
    check("release_latency", n, 32'd6);
    ler_da_entrada = 1'b0;
    tick();
    check("idle_stall", {31'b0, stall_pc}, 32'd0);
    confirma_entrada = 1'b1;
    #1;
    check("confirm_value", dado_entrada, exp_entrada);
    tick();
    confirma_entrada = 1'b0;
    chaves = $urandom;
    repeat (4) tick();
    check("value_holds", dado_entrada, exp_entrada);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    ler_da_entrada = 1'b0;
    confirma_entrada = 1'b0;
    print = 1'b0;
    botao_n = 1'b1;
    chaves = 16'h0;
    dado_saida = 32'h0;
    repeat (3) tick();
    check("reset_stall", {31'b0, stall_pc}, 32'd0);
    check("reset_display", display_valor, 32'h0);
    check("reset_valid", {31'b0, display_valido}, 32'd0);
    check("reset_entrada", dado_entrada, 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    do_wait(16'hA5C3, 1'b0, 1'b0);
    check("wait_a5c3", dado_entrada, 32'h0000A5C3);

    do_print(32'hDEADBEEF);
    do_print(32'h12345678);
    check("print_last_wins", display_valor, 32'h12345678);
    check("print_valid", {31'b0, display_valido}, 32'd1);

    do_wait(16'h3C5A, 1'b1, 1'b0);
    do_wait(16'h0F0F, 1'b0, 1'b1);

    for (int it = 0; it < 6; it++) begin
      int np;
      np = $urandom_range(0, 2);
      for (int k = 0; k < np; k++) do_print($urandom);
      do_wait(16'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      check("rand_display", display_valor, exp_disp);
      check("rand_valid", {31'b0, display_valido}, {31'b0, exp_valid});
    end

`ifdef IO_TIMEOUT_EN
    botao_n = 1'b1;
    chaves = 16'hFFFF;
    ler_da_entrada = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (stall_pc && n < 200);
    check("timeout_latency", n, 32'd65);
    check("timeout_flag_set", {31'b0, timeout_flag}, 32'd1);
    check("timeout_keeps_value", dado_entrada, exp_entrada);
    ler_da_entrada = 1'b0;
    tick();
    do_wait(16'h1234, 1'b0, 1'b0);
`else
    check("timeout_tied_low", {31'b0, timeout_flag}, 32'd0);
`endif

    ler_da_entrada = 1'b1;
    tick();
    ler_da_entrada = 1'b0;
    botao_n = 1'b0;
    repeat (6) tick();
    check("pre_reset_release_state", {31'b0, aguardando}, 32'd0);
    check("pre_reset_stall", {31'b0, stall_pc}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_stall", {31'b0, stall_pc}, 32'd0);
    check("async_reset_display", display_valor, 32'h0);
    check("async_reset_valid", {31'b0, display_valido}, 32'd0);
    check("async_reset_entrada", dado_entrada, 32'h0);
    check("async_reset_aguardando", {31'b0, aguardando}, 32'd0);
    botao_n = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    ler_da_entrada = 1'b1;
    #1;
    check("post_reset_decode", {31'b0, stall_pc}, 32'd1);
    tick();
    check("post_reset_wait", {31'b0, aguardando}, 32'd1);
    ler_da_entrada = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
